// File: rtl/sa_ctrl_pkg.sv
// Shared types and helpers for the systolic-array job sequencer.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } sa_ctrl_state_e;

  // Bit width needed to index n items; never narrower than one bit.
  function automatic int unsigned sa_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_valid_pipe.sv
// Issue-aligned delay line: per-column output-valid taps and the column-0
// drain index for the weight-stationary array.
module sa_valid_pipe #(
  parameter int OFFSET   = 5,
  parameter int NUM_COLS = 4,
  parameter int VEC_W    = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_issue,
  input  logic                i_clr,
  output logic [NUM_COLS-1:0] o_col_valid,
  output logic [VEC_W-1:0]    o_drain_idx,
  output logic                o_empty_next
);

  localparam int DEPTH = OFFSET + NUM_COLS - 1;

  logic [DEPTH-1:0] sr_q, sr_d;
  logic [VEC_W-1:0] drain_idx_q, drain_idx_d;

  // sr_q[k] holds the issue flag from k+1 cycles ago.
  assign o_col_valid  = sr_q[OFFSET-1 +: NUM_COLS];
  assign o_drain_idx  = drain_idx_q;
  assign o_empty_next = (sr_d == '0);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sr_d        = (sr_q << 1) | DEPTH'(i_issue);
    drain_idx_d = drain_idx_q;
    if (i_clr) begin
      drain_idx_d = '0;
    end else if (o_col_valid[0]) begin
      drain_idx_d = drain_idx_q + VEC_W'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      drain_idx_q <= '0;
    end else begin
      sr_q        <= sr_d;
      drain_idx_q <= drain_idx_d;
    end
  end

endmodule

// File: rtl/sa_controller.sv
// Job sequencer for the weight-stationary PE array: weight preload, activation
// streaming, drain. Optional perf counters under `define SA_CTRL_PERF_EN.
module sa_controller
  import sa_ctrl_pkg::*;
#(
  parameter int NUM_ROWS  = 4,
  parameter int NUM_COLS  = 4,
  parameter int MAX_VEC   = 256,
  parameter int RD_LAT    = 1,
  parameter int ARRAY_LAT = 4,
  parameter int VEC_W     = $clog2(MAX_VEC + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [VEC_W-1:0]              i_num_vec,
  input  logic                          i_skip_wload,
  input  logic                          i_acc,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_mode,
  output logic                          o_load_psum,
  output logic                          o_psum_clr,
  output logic                          o_w_rd_en,
  output logic [sa_width(NUM_ROWS)-1:0] o_w_rd_addr,
  output logic                          o_a_rd_en,
  output logic                          o_p_rd_en,
  output logic [VEC_W-1:0]              o_vec_addr,
  output logic [NUM_COLS-1:0]           o_col_valid,
  output logic [VEC_W-1:0]              o_drain_idx
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]                   o_perf_cycles,
  output logic [31:0]                   o_perf_jobs
`endif
);

  localparam int AW = sa_width(NUM_ROWS);

  sa_ctrl_state_e   state_q, state_d;
  logic [VEC_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] num_vec_q, num_vec_d;
  logic             acc_q, acc_d;
  logic             pipe_empty_next;
  logic             mode_flag, load_psum_flag;

  // State and job registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_vec_q <= '0;
      acc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_vec_q <= num_vec_d;
      acc_q     <= acc_d;
    end
  end

  // Next state and job bookkeeping
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_vec_d = num_vec_q;
    acc_d     = acc_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_start) begin
          state_d   = i_skip_wload ? STREAM : LOAD_W;
          acc_d     = i_acc;
          num_vec_d = (i_num_vec == '0)               ? VEC_W'(1) :
                      (i_num_vec > VEC_W'(MAX_VEC))   ? VEC_W'(MAX_VEC) : i_num_vec;
        end
      end
      LOAD_W: begin
        if (cnt_q == VEC_W'(NUM_ROWS - 1)) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + VEC_W'(1);
        end
      end
      STREAM: begin
        cnt_d = cnt_q + VEC_W'(1);
        if (cnt_q == num_vec_q - VEC_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = '0;
        if (pipe_empty_next) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue-aligned outputs
  always_comb begin
    o_busy         = (state_q != IDLE);
    o_done         = (state_q == DONE);
    o_w_rd_en      = (state_q == LOAD_W);
    o_w_rd_addr    = o_w_rd_en ? AW'(VEC_W'(NUM_ROWS - 1) - cnt_q) : '0;
    o_a_rd_en      = (state_q == STREAM);
    o_p_rd_en      = o_a_rd_en & acc_q;
    o_vec_addr     = o_a_rd_en ? cnt_q : '0;
    o_psum_clr     = o_busy & ~acc_q;
    mode_flag      = (state_q != LOAD_W);
    load_psum_flag = (state_q == STREAM) || (state_q == DRAIN);
  end

  // Array control follows the data, so the phase flags ride the read latency.
  if (RD_LAT == 0) begin : g_no_rd_lat
    assign o_mode      = mode_flag;
    assign o_load_psum = load_psum_flag;
  end else begin : g_rd_lat
    logic [RD_LAT-1:0] mode_dly_q, mode_dly_d;
    logic [RD_LAT-1:0] lp_dly_q, lp_dly_d;

    always_comb begin
      mode_dly_d = (mode_dly_q << 1) | RD_LAT'(mode_flag);
      lp_dly_d   = (lp_dly_q << 1) | RD_LAT'(load_psum_flag);
    end

    // Mode resets to 1 so resident weights are never shifted by accident.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_dly_q <= '1;
        lp_dly_q   <= '0;
      end else begin
        mode_dly_q <= mode_dly_d;
        lp_dly_q   <= lp_dly_d;
      end
    end

    assign o_mode      = mode_dly_q[RD_LAT-1];
    assign o_load_psum = lp_dly_q[RD_LAT-1];
  end

  sa_valid_pipe #(
    .OFFSET   (RD_LAT + ARRAY_LAT),
    .NUM_COLS (NUM_COLS),
    .VEC_W    (VEC_W)
  ) u_valid_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_issue      (o_a_rd_en),
    .i_clr        (state_q == IDLE),
    .o_col_valid  (o_col_valid),
    .o_drain_idx  (o_drain_idx),
    .o_empty_next (pipe_empty_next)
  );

`ifdef SA_CTRL_PERF_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_jobs_q, perf_jobs_d;

  // The DONE cycle itself is a busy cycle, hence the +1 when publishing.
  always_comb begin
    run_cnt_d     = run_cnt_q;
    perf_cycles_d = perf_cycles_q;
    perf_jobs_d   = perf_jobs_q;
    if (!o_busy) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != '1) begin
      run_cnt_d = run_cnt_q + 32'd1;
    end
    if (o_done) begin
      perf_cycles_d = (run_cnt_q == '1) ? '1 : run_cnt_q + 32'd1;
      perf_jobs_d   = (perf_jobs_q == '1) ? '1 : perf_jobs_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q     <= '0;
      perf_cycles_q <= '0;
      perf_jobs_q   <= '0;
    end else begin
      run_cnt_q     <= run_cnt_d;
      perf_cycles_q <= perf_cycles_d;
      perf_jobs_q   <= perf_jobs_d;
    end
  end

  assign o_perf_cycles = perf_cycles_q;
  assign o_perf_jobs   = perf_jobs_q;
`endif

endmodule

// File: tb/tb_sa_controller.sv
// Self-checking bench for sa_controller: directed jobs plus randomized jobs,
// each cycle compared against a schedule derived from the job parameters.
module tb_sa_controller;

  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int MV  = 256;
  localparam int RDL = 1;
  localparam int AL  = 4;
  localparam int VW  = $clog2(MV + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_skip_wload, i_acc;
  logic [VW-1:0] i_num_vec;
  logic          o_busy, o_done, o_mode, o_load_psum, o_psum_clr;
  logic          o_w_rd_en, o_a_rd_en, o_p_rd_en;
  logic [1:0]    o_w_rd_addr;
  logic [VW-1:0] o_vec_addr, o_drain_idx;
  logic [NC-1:0] o_col_valid;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]   o_perf_cycles, o_perf_jobs;
`endif

  always #5 clk = ~clk;

  sa_controller #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .MAX_VEC(MV), .RD_LAT(RDL), .ARRAY_LAT(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_vec(i_num_vec),
    .i_skip_wload(i_skip_wload), .i_acc(i_acc), .o_busy(o_busy), .o_done(o_done),
    .o_mode(o_mode), .o_load_psum(o_load_psum), .o_psum_clr(o_psum_clr),
    .o_w_rd_en(o_w_rd_en), .o_w_rd_addr(o_w_rd_addr), .o_a_rd_en(o_a_rd_en),
    .o_p_rd_en(o_p_rd_en), .o_vec_addr(o_vec_addr), .o_col_valid(o_col_valid),
    .o_drain_idx(o_drain_idx)
`ifdef SA_CTRL_PERF_EN
    , .o_perf_cycles(o_perf_cycles), .o_perf_jobs(o_perf_jobs)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int a_cnt;
  int col_cnt [NC];
  int jobs_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_eff(input int n);
    if (n == 0) return 1;
    if (n > MV) return MV;
    return n;
  endfunction

  task automatic check_reset_vals();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_mode", o_mode, 1);
    check("rst_lpsum", o_load_psum, 0);
    check("rst_clr", o_psum_clr, 0);
    check("rst_w_en", o_w_rd_en, 0);
    check("rst_w_addr", o_w_rd_addr, 0);
    check("rst_a_en", o_a_rd_en, 0);
    check("rst_p_en", o_p_rd_en, 0);
    check("rst_vaddr", o_vec_addr, 0);
    check("rst_colv", o_col_valid, 0);
    check("rst_didx", o_drain_idx, 0);
  endtask

  // Expected outputs at cycle rel of a job (rel 0 = start sampled in IDLE).
  task automatic check_cycle(input int rel, input int l0, input int n, input bit acc,
                             input int done_rel);
    bit            w_en, a_en, busy;
    logic [NC-1:0] colv;
    int            v0, v;
    w_en = (rel >= 1) && (rel <= l0);
    a_en = (rel >= l0 + 1) && (rel <= l0 + n);
    busy = (rel >= 1) && (rel <= done_rel);
    colv = '0;
    v0   = 0;
    for (int c = 0; c < NC; c++) begin
      v = rel - (l0 + 1 + RDL + AL + c);
      if (v >= 0 && v < n) colv[c] = 1'b1;
      if (c == 0) v0 = v;
    end
    check("busy", o_busy, busy);
    check("done", o_done, rel == done_rel);
    check("mode", o_mode, !((rel >= 1 + RDL) && (rel <= l0 + RDL)));
    check("w_en", o_w_rd_en, w_en);
    check("a_en", o_a_rd_en, a_en);
    check("p_en", o_p_rd_en, a_en && acc);
    check("psum_clr", o_psum_clr, busy && !acc);
    check("col_valid", o_col_valid, colv);
    if (w_en) check("w_addr", o_w_rd_addr, NR - rel);
    if (a_en) check("vec_addr", o_vec_addr, rel - l0 - 1);
    if (colv[0]) check("drain_idx", o_drain_idx, v0);
    if ((rel >= 1 + RDL) && (rel <= l0 + RDL)) check("lpsum_w", o_load_psum, 0);
    if ((rel >= l0 + 1 + RDL) && (rel <= l0 + n + RDL)) check("lpsum_a", o_load_psum, 1);
    a_cnt += int'(o_a_rd_en);
    for (int c = 0; c < NC; c++) col_cnt[c] += int'(o_col_valid[c]);
  endtask

  // Entered and left #1 after a rising edge. abort_at >= 0 asserts reset mid-job.
  task automatic run_job(input int n_req, input bit skip, input bit acc, input bit hold,
                         input int abort_at);
    int n, l0, done_rel;
    n        = n_eff(n_req);
    l0       = skip ? 0 : NR;
    done_rel = l0 + n + RDL + AL + NC;
    a_cnt    = 0;
    for (int c = 0; c < NC; c++) col_cnt[c] = 0;
    i_start      = 1'b1;
    i_num_vec    = VW'(n_req);
    i_skip_wload = skip;
    i_acc        = acc;
    for (int rel = 0; rel <= done_rel; rel++) begin
      @(negedge clk);
      check_cycle(rel, l0, n, acc, done_rel);
      if (rel == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        jobs_done = 0;
        return;
      end
      @(posedge clk);
      #1;
      if (!hold) i_start = 1'b0;
      i_num_vec    = VW'($urandom);
      i_skip_wload = 1'($urandom);
      i_acc        = 1'($urandom);
    end
    jobs_done++;
    check("a_reads", a_cnt, n);
    for (int c = 0; c < NC; c++) check($sformatf("col%0d_count", c), col_cnt[c], n);
`ifdef SA_CTRL_PERF_EN
    check("perf_cycles", o_perf_cycles, done_rel);
    check("perf_jobs", o_perf_jobs, jobs_done);
`endif
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle_busy", o_busy, 0);
      check("idle_mode", o_mode, 1);
      check("idle_a_en", o_a_rd_en, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    i_start      = 1'b0;
    i_num_vec    = '0;
    i_skip_wload = 1'b0;
    i_acc        = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_job(3, 0, 0, 0, -1);
    idle(2);
    run_job(2, 1, 1, 0, -1);
    idle(1);
    // Start held across a whole job: the follow-up job begins after DONE.
    run_job(4, 0, 1, 1, -1);
    run_job(2, 1, 0, 0, -1);
    idle(3);

    // Reset in mid-STREAM, then the reference job again.
    run_job(5, 0, 0, 0, 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_done", o_done, 0);
      check("abort_busy", o_busy, 0);
    end
    @(posedge clk);
    #1;
    i_start = 1'b0;
    rst_n   = 1'b1;
    idle(2);
    run_job(3, 0, 0, 0, -1);
    idle(1);

    run_job(0, 0, 1, 0, -1);
    idle(1);
    run_job(MV + 5, 1, 0, 0, -1);
    idle(1);

    for (int j = 0; j < 25; j++) begin
      bit hold;
      hold = 1'($urandom);
      run_job(int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom), hold, -1);
      if (!hold) idle(int'($urandom_range(0, 3)));
    end
    i_start = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
